// File: rtl/operand_fetch_pkg.sv
// Shared widths, forwarding-source encoding and stage bundle types
// for the operand fetch stage.
package operand_fetch_pkg;

  localparam int GPR_WIDTH          = 32;
  localparam int REGISTER_FILE_SIZE = 16;
  localparam int NUM_REGS           = REGISTER_FILE_SIZE;
  localparam int ADDR_W             = 5;
  localparam int IDX_W              = $clog2(NUM_REGS);
  localparam int STALL_CNT_W        = 16;

  typedef logic [GPR_WIDTH-1:0]   gpr_t;
  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Forwarding source; EX is highest priority, RF the fallback.
  typedef enum logic [2:0] {
    FWD_RF  = 3'd0,
    FWD_EX  = 3'd1,
    FWD_MEM = 3'd2,
    FWD_LD  = 3'd3,
    FWD_WB  = 3'd4
  } fwd_src_e;

  typedef struct packed {
    logic  wr_en;
    addr_t rd;
    gpr_t  data;
  } fwd_t;

  typedef struct packed {
    gpr_t  rs_data;
    gpr_t  rt_data;
    addr_t rd;
    logic  rd_write;
    logic  is_load;
  } of_t;

  function automatic logic reg_valid(addr_t a);
    return a < ADDR_W'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(addr_t a);
    return IDX_W'(a);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode->OF and OF->EX valid/ready handshakes.
// master: decode/execute side, slave: operand_fetch.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic  id_valid;
  logic  id_ready;
  addr_t id_rs;
  addr_t id_rt;
  addr_t id_rd;
  logic  id_rd_write;
  logic  id_is_load;

  logic  of_valid;
  logic  of_ready;
  gpr_t  of_rs_data;
  gpr_t  of_rt_data;
  addr_t of_rd;
  logic  of_rd_write;
  logic  of_is_load;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_rd_write, id_is_load, of_ready,
    input  id_ready, of_valid, of_rs_data,
    input  of_rt_data, of_rd, of_rd_write,
    input  of_is_load
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_rd_write, id_is_load, of_ready,
    output id_ready, of_valid, of_rs_data,
    output of_rt_data, of_rd, of_rd_write,
    output of_is_load
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding mux: EX > MEM > LD > WB > RF.
// Ports: addr, rf_data, four source tuples in; data out.
module operand_fwd_mux
  import operand_fetch_pkg::*;
(
  input  addr_t addr,
  input  gpr_t  rf_data,
  input  fwd_t  ex,
  input  fwd_t  mem,
  input  fwd_t  ld,
  input  fwd_t  wb,
  output gpr_t  data
);

  fwd_src_e sel;

  always_comb begin
    if (ex.wr_en && ex.rd == addr)
      sel = FWD_EX;
    else if (mem.wr_en && mem.rd == addr)
      sel = FWD_MEM;
    else if (ld.wr_en && ld.rd == addr)
      sel = FWD_LD;
    else if (wb.wr_en && wb.rd == addr)
      sel = FWD_WB;
    else
      sel = FWD_RF;
  end

  always_comb begin
    unique case (sel)
      FWD_EX:  data = ex.data;
      FWD_MEM: data = mem.data;
      FWD_LD:  data = ld.data;
      FWD_WB:  data = wb.data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: RF read, forwarding, load scoreboard, stall count.
// Ports: clk/rst, io (slave), RF read, EX/MEM/LD/WB, flush, stall_cnt.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  operand_fetch_if.slave io,
  output addr_t      rf_rs,
  output addr_t      rf_rt,
  input  gpr_t       rf_data_rs,
  input  gpr_t       rf_data_rt,
  input  logic       ex_wr_en,
  input  addr_t      ex_rd,
  input  gpr_t       ex_data,
  input  logic       mem_wr_en,
  input  addr_t      mem_rd,
  input  gpr_t       mem_data,
  input  logic       ld_done,
  input  addr_t      ld_rd,
  input  gpr_t       ld_data,
  input  logic       wb_wr_en,
  input  addr_t      wb_rd,
  input  gpr_t       wb_data,
  input  logic       flush,
  output stall_cnt_t stall_cnt
);

  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                of_valid_q, of_valid_d;
  of_t                 of_q, of_d;
  stall_cnt_t          stall_q, stall_d;

  fwd_t ex_f, mem_f, ld_f, wb_f;
  gpr_t rs_fwd, rt_fwd;
  logic rs_blk, rt_blk, rd_blk;
  logic hazard, id_ready, accept;

  assign rf_rs = io.id_rs;
  assign rf_rt = io.id_rt;

  assign ex_f  = '{ex_wr_en, ex_rd, ex_data};
  assign mem_f = '{mem_wr_en, mem_rd, mem_data};
  assign ld_f  = '{ld_done, ld_rd, ld_data};
  assign wb_f  = '{wb_wr_en, wb_rd, wb_data};

  operand_fwd_mux u_fwd_rs (
    .addr    (io.id_rs),
    .rf_data (rf_data_rs),
    .ex      (ex_f),
    .mem     (mem_f),
    .ld      (ld_f),
    .wb      (wb_f),
    .data    (rs_fwd)
  );

  operand_fwd_mux u_fwd_rt (
    .addr    (io.id_rt),
    .rf_data (rf_data_rt),
    .ex      (ex_f),
    .mem     (mem_f),
    .ld      (ld_f),
    .wb      (wb_f),
    .data    (rt_fwd)
  );

  // A pending register returning this very cycle is forwarded, not stalled.
  always_comb begin
    rs_blk = reg_valid(io.id_rs)
           && sb_q[reg_idx(io.id_rs)]
           && !(ld_done && ld_rd == io.id_rs);
    rt_blk = reg_valid(io.id_rt)
           && sb_q[reg_idx(io.id_rt)]
           && !(ld_done && ld_rd == io.id_rt);
    rd_blk = reg_valid(io.id_rd)
           && sb_q[reg_idx(io.id_rd)]
           && !(ld_done && ld_rd == io.id_rd);
    hazard = io.id_valid
           && (rs_blk || rt_blk
               || (io.id_rd_write && rd_blk));
  end

  assign id_ready = !flush && !hazard
                  && (!of_valid_q || io.of_ready);
  assign accept   = io.id_valid && id_ready;

  always_comb begin
    sb_d = sb_q;
    if (ld_done && reg_valid(ld_rd))
      sb_d[reg_idx(ld_rd)] = 1'b0;
    // A newly issued load to the returning register wins.
    if (accept && io.id_is_load
        && io.id_rd_write && reg_valid(io.id_rd))
      sb_d[reg_idx(io.id_rd)] = 1'b1;

    of_valid_d = of_valid_q;
    of_d       = of_q;
    if (flush) begin
      of_valid_d = 1'b0;
    end else if (accept) begin
      of_valid_d = 1'b1;
      of_d = '{
        rs_data:  rs_fwd,
        rt_data:  rt_fwd,
        rd:       io.id_rd,
        rd_write: io.id_rd_write,
        is_load:  io.id_is_load
      };
    end else if (io.of_ready) begin
      of_valid_d = 1'b0;
    end

    stall_d = stall_q;
    if (hazard && !flush && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q       <= '0;
      of_valid_q <= 1'b0;
      of_q       <= '0;
      stall_q    <= '0;
    end else begin
      sb_q       <= sb_d;
      of_valid_q <= of_valid_d;
      of_q       <= of_d;
      stall_q    <= stall_d;
    end
  end

  assign io.id_ready    = id_ready;
  assign io.of_valid    = of_valid_q;
  assign io.of_rs_data  = of_q.rs_data;
  assign io.of_rt_data  = of_q.rt_data;
  assign io.of_rd       = of_q.rd;
  assign io.of_rd_write = of_q.rd_write;
  assign io.of_is_load  = of_q.is_load;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed plan scenarios, then random
// traffic against a behavioural model of forwarding and hazards.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  addr_t      rf_rs, rf_rt;
  gpr_t       rf_data_rs, rf_data_rt;
  logic       ex_wr_en, mem_wr_en, ld_done, wb_wr_en;
  addr_t      ex_rd, mem_rd, ld_rd, wb_rd;
  gpr_t       ex_data, mem_data, ld_data, wb_data;
  logic       flush;
  stall_cnt_t stall_cnt;

  operand_fetch_if io ();

  operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .io         (io),
    .rf_rs      (rf_rs),
    .rf_rt      (rf_rt),
    .rf_data_rs (rf_data_rs),
    .rf_data_rt (rf_data_rt),
    .ex_wr_en   (ex_wr_en),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .mem_wr_en  (mem_wr_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .ld_done    (ld_done),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .stall_cnt  (stall_cnt)
  );

  // Register file model: read is combinational, write lands at the edge.
  gpr_t rf_m [32];
  assign rf_data_rs = rf_m[rf_rs];
  assign rf_data_rt = rf_m[rf_rt];
  always @(posedge clk)
    if (wb_wr_en && wb_rd < 5'd16) rf_m[wb_rd] = wb_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [15:0] m_sb;
  logic      m_valid;
  gpr_t      m_rsd, m_rtd;
  addr_t     m_rd;
  logic      m_rdw, m_ld;
  int        m_stall;
  logic      exp_rdy, obs_rdy;
  bit        chk_rdy;

  // Apply sources lowest priority first so the highest one ends up on top.
  function automatic gpr_t fwd_ref(addr_t a);
    gpr_t r = rf_m[a];
    if (wb_wr_en  && wb_rd  == a) r = wb_data;
    if (ld_done   && ld_rd  == a) r = ld_data;
    if (mem_wr_en && mem_rd == a) r = mem_data;
    if (ex_wr_en  && ex_rd  == a) r = ex_data;
    return r;
  endfunction

  function automatic bit blocked(addr_t a);
    if (a >= 5'd16) return 1'b0;
    return m_sb[a[3:0]] && !(ld_done && ld_rd == a);
  endfunction

  task automatic tick();
    bit   haz;
    logic rdy;
    #1;
    chk_rdy = 1'b0;
    if (rst) begin
      m_sb = '0; m_valid = 0; m_rsd = '0; m_rtd = '0;
      m_rd = '0; m_rdw = 0; m_ld = 0; m_stall = 0;
    end else begin
      haz = io.id_valid && (blocked(io.id_rs) || blocked(io.id_rt)
            || (io.id_rd_write && blocked(io.id_rd)));
      rdy = !flush && !haz && (!m_valid || io.of_ready);
      exp_rdy = rdy;
      obs_rdy = io.id_ready;
      chk_rdy = 1'b1;
      if (io.id_valid && haz && !flush && m_stall < 65535)
        m_stall++;
      if (ld_done && ld_rd < 5'd16) m_sb[ld_rd[3:0]] = 1'b0;
      if (io.id_valid && rdy && io.id_is_load && io.id_rd_write
          && io.id_rd < 5'd16)
        m_sb[io.id_rd[3:0]] = 1'b1;
      if (flush) m_valid = 0;
      else if (io.id_valid && rdy) begin
        m_valid = 1;
        m_rsd = fwd_ref(io.id_rs);
        m_rtd = fwd_ref(io.id_rt);
        m_rd = io.id_rd; m_rdw = io.id_rd_write; m_ld = io.id_is_load;
      end else if (io.of_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io.id_valid = 0; io.id_rs = '0; io.id_rt = '0; io.id_rd = '0;
    io.id_rd_write = 0; io.id_is_load = 0; io.of_ready = 1;
    ex_wr_en = 0; ex_rd = '0; ex_data = '0;
    mem_wr_en = 0; mem_rd = '0; mem_data = '0;
    ld_done = 0; ld_rd = '0; ld_data = '0;
    wb_wr_en = 0; wb_rd = '0; wb_data = '0;
    flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if (io.of_valid !== 1'b0) begin
      errors++; $display("FAIL reset_of_valid: got %b want 0", io.of_valid);
    end
    checks++;
    if (io.of_rs_data !== '0 || io.of_rt_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h want 0/0", io.of_rs_data, io.of_rt_data);
    end
    checks++;
    if (io.of_rd !== '0 || io.of_rd_write !== 1'b0 || io.of_is_load !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got %h %b %b want 0 0 0", io.of_rd, io.of_rd_write, io.of_is_load);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
    checks++;
    if (io.id_ready !== 1'b1) begin
      errors++; $display("FAIL reset_id_ready: got %b want 1", io.id_ready);
    end
  endtask

  task automatic test_basic_read();
    rf_m[3] = 32'h11; rf_m[4] = 32'h22;
    io.id_valid = 1; io.id_rs = 5'd3; io.id_rt = 5'd4;
    io.id_rd = 5'd6; io.id_rd_write = 1;
    tick();
    checks++;
    if (io.of_valid !== 1'b1 || io.of_rs_data !== 32'h11 || io.of_rt_data !== 32'h22) begin
      errors++;
      $display("FAIL basic_read: got v=%b %h %h want v=1 11 22", io.of_valid, io.of_rs_data, io.of_rt_data);
    end
  endtask

  task automatic test_fwd_priority();
    io.id_rs = 5'd3; io.id_rt = 5'd4;
    ex_wr_en = 1; ex_rd = 5'd3; ex_data = 32'hAA;
    mem_wr_en = 1; mem_rd = 5'd3; mem_data = 32'hBB;
    wb_wr_en = 1; wb_rd = 5'd4; wb_data = 32'h55;
    tick();
    checks++;
    if (io.of_rs_data !== 32'hAA) begin
      errors++; $display("FAIL fwd_ex_over_mem: got %h want aa", io.of_rs_data);
    end
    checks++;
    if (io.of_rt_data !== 32'h55) begin
      errors++; $display("FAIL fwd_wb: got %h want 55", io.of_rt_data);
    end
    ex_wr_en = 0; mem_wr_en = 0; wb_wr_en = 0;
    io.id_rs = 5'd1; io.id_rt = 5'd3;
    mem_wr_en = 1; mem_rd = 5'd1; mem_data = 32'hBB;
    ld_done = 1; ld_rd = 5'd1; ld_data = 32'h99;
    tick();
    checks++;
    if (io.of_rs_data !== 32'hBB || io.of_rt_data !== 32'h11) begin
      errors++; $display("FAIL fwd_mem_over_ld: got %h %h want bb 11", io.of_rs_data, io.of_rt_data);
    end
    mem_wr_en = 0; ld_done = 0;
  endtask

  task automatic test_load_stall();
    io.id_valid = 1; io.id_rs = 5'd0; io.id_rt = 5'd0;
    io.id_rd = 5'd5; io.id_rd_write = 1; io.id_is_load = 1;
    tick();
    io.id_rs = 5'd5; io.id_rt = 5'd1; io.id_rd = 5'd7; io.id_is_load = 0;
    #1;
    checks++;
    if (io.id_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall_ready: got %b want 0", io.id_ready);
    end
    tick(); tick(); tick();
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_load_return();
    ld_done = 1; ld_rd = 5'd5; ld_data = 32'h77;
    #1;
    checks++;
    if (io.id_ready !== 1'b1) begin
      errors++; $display("FAIL ld_return_ready: got %b want 1", io.id_ready);
    end
    tick();
    ld_done = 0;
    checks++;
    if (io.of_valid !== 1'b1 || io.of_rs_data !== 32'h77 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ld_return_data: got v=%b %h cnt=%0d want v=1 77 cnt=3", io.of_valid, io.of_rs_data, stall_cnt);
    end
    #1;
    checks++;
    if (io.id_ready !== 1'b1) begin
      errors++; $display("FAIL ld_bit_cleared: got ready %b want 1", io.id_ready);
    end
    tick();
  endtask

  task automatic test_backpressure_flush();
    io.id_rs = 5'd0; io.id_rt = 5'd0; io.id_rd = 5'd9;
    io.id_rd_write = 1; io.id_is_load = 1;
    tick();
    io.of_ready = 0;
    io.id_rs = 5'd1; io.id_rt = 5'd2; io.id_rd = 5'd3; io.id_is_load = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (io.id_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, io.id_ready);
      end
      tick();
      checks++;
      if (io.of_valid !== 1'b1 || io.of_rd !== 5'd9 || io.of_is_load !== 1'b1
          || io.of_rs_data !== 32'h0 || stall_cnt !== 16'd3) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b rd=%0d ld=%b rs=%h cnt=%0d want 1 9 1 0 3",
                 i, io.of_valid, io.of_rd, io.of_is_load, io.of_rs_data, stall_cnt);
      end
    end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (io.of_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b want 0", io.of_valid);
    end
    io.of_ready = 1; io.id_rs = 5'd9; io.id_rt = 5'd0; io.id_rd_write = 0;
    #1;
    checks++;
    if (io.id_ready !== 1'b0) begin
      errors++; $display("FAIL flush_keeps_pending: got ready %b want 0", io.id_ready);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++; $display("FAIL flush_stall_cnt: got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_reset_midload();
    io.id_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    io.id_valid = 1; io.id_rs = 5'd9; io.id_rt = 5'd9;
    io.id_rd = 5'd9; io.id_rd_write = 1; io.id_is_load = 0;
    #1;
    checks++;
    if (io.id_ready !== 1'b1 || stall_cnt !== '0) begin
      errors++; $display("FAIL reset_clears_sb: got ready %b cnt %0d want 1 0", io.id_ready, stall_cnt);
    end
    tick();
    io.id_valid = 0;
  endtask

  task automatic test_out_of_range();
    io.id_valid = 1; io.id_rs = 5'd20; io.id_rt = 5'd0;
    io.id_rd = 5'd20; io.id_rd_write = 1; io.id_is_load = 1;
    rf_m[20] = 32'hCAFE;
    tick();
    checks++;
    if (io.of_valid !== 1'b1 || io.of_rs_data !== 32'hCAFE) begin
      errors++; $display("FAIL oor_pass: got v=%b %h want 1 cafe", io.of_valid, io.of_rs_data);
    end
    io.id_is_load = 0;
    #1;
    checks++;
    if (io.id_ready !== 1'b1) begin
      errors++; $display("FAIL oor_no_hazard: got %b want 1", io.id_ready);
    end
    tick();
    io.id_valid = 0;
  endtask

  function automatic addr_t rnd_src();
    if ($urandom_range(0, 7) == 0) return addr_t'($urandom_range(16, 31));
    return addr_t'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 32; i++) rf_m[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      io.id_valid = ($urandom_range(0, 3) != 0);
      io.id_rs = rnd_src(); io.id_rt = rnd_src(); io.id_rd = rnd_src();
      io.id_rd_write = ($urandom_range(0, 3) != 0);
      io.id_is_load = ($urandom_range(0, 9) < 3);
      io.of_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_wr_en = $urandom_range(0, 1); ex_rd = addr_t'($urandom_range(0, 7)); ex_data = $urandom;
      mem_wr_en = $urandom_range(0, 1); mem_rd = addr_t'($urandom_range(0, 7)); mem_data = $urandom;
      ld_done = ($urandom_range(0, 3) == 0); ld_rd = addr_t'($urandom_range(0, 7)); ld_data = $urandom;
      wb_wr_en = $urandom_range(0, 1); wb_rd = addr_t'($urandom_range(0, 7)); wb_data = $urandom;
      tick();
      if (chk_rdy) begin
        checks++;
        if (obs_rdy !== exp_rdy) begin
          errors++; $display("FAIL rnd_id_ready[%0d]: got %b want %b", n, obs_rdy, exp_rdy);
        end
      end
      checks++;
      if (io.of_valid !== m_valid) begin
        errors++; $display("FAIL rnd_of_valid[%0d]: got %b want %b", n, io.of_valid, m_valid);
      end
      checks++;
      if (io.of_rs_data !== m_rsd || io.of_rt_data !== m_rtd) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got %h %h want %h %h", n, io.of_rs_data, io.of_rt_data, m_rsd, m_rtd);
      end
      checks++;
      if (io.of_rd !== m_rd || io.of_rd_write !== m_rdw || io.of_is_load !== m_ld) begin
        errors++;
        $display("FAIL rnd_ctrl[%0d]: got %0d %b %b want %0d %b %b", n, io.of_rd, io.of_rd_write,
                 io.of_is_load, m_rd, m_rdw, m_ld);
      end
      checks++;
      if (int'(stall_cnt) != m_stall) begin
        errors++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, m_stall);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 0;
    test_reset();
    test_basic_read();
    test_fwd_priority();
    test_load_stall();
    test_load_return();
    test_backpressure_flush();
    test_reset_midload();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
